// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: game states, directions
// and the reverse-direction helper.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DIE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_score_bcd.sv
// Four-digit BCD score counter; clear wins over inc, and the count
// saturates at 9999.
module snake_score_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] score
);

  logic [15:0] score_n;
  logic        carry;

  always_comb begin
    score_n = score;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score[i*4 +: 4] == 4'd9) begin
          score_n[i*4 +: 4] = 4'd0;
        end else begin
          score_n[i*4 +: 4] = score[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score <= 16'h0000;
    end else if (clear) begin
      score <= 16'h0000;
    end else if (inc && score != 16'h9999) begin
      score <= score_n;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: button edge detect, IDLE/PLAY/DIE state machine,
// move tick generation, DIE timer and score keeping. All outputs registered.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a button event to start; last score shown
//   ST_PLAY | snake moving, turns queued in pending_dir, apples scored
//   ST_DIE  | collision seen; everything frozen for DIE_CYCLES cycles
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int MOVE_DIV   = 25000000,
  parameter int DIE_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        hit,
  input  logic        apple_eaten,
  output logic [1:0]  game_state,
  output logic [1:0]  dir,
  output logic        move_tick,
  output logic        init,
  output logic        grow,
  output logic [15:0] score_bcd
);

  localparam int TICK_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int DIE_W  = (DIE_CYCLES > 1) ? $clog2(DIE_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(MOVE_DIV - 1);
  localparam logic [DIE_W-1:0]  DIE_LOAD = DIE_W'(DIE_CYCLES - 1);

  state_t            state, state_n;
  dir_t              dir_q, dir_n, pend_q, pend_n, ev_dir;
  logic [TICK_W-1:0] tick_cnt, tick_n;
  logic [DIE_W-1:0]  die_cnt, die_n;
  logic [3:0]        btn, btn_q, ev;
  logic              ev_any;
  logic              move_tick_n, init_n, grow_n;
  logic              score_clr, score_inc;

  assign btn = {up, down, left, right};
  assign ev  = btn & ~btn_q;

  always_comb begin
    ev_any = 1'b1;
    ev_dir = DIR_RIGHT;
    if (ev[3])      ev_dir = DIR_UP;
    else if (ev[2]) ev_dir = DIR_DOWN;
    else if (ev[1]) ev_dir = DIR_LEFT;
    else if (ev[0]) ev_dir = DIR_RIGHT;
    else            ev_any = 1'b0;
  end

  always_comb begin
    state_n     = state;
    dir_n       = dir_q;
    pend_n      = pend_q;
    tick_n      = tick_cnt;
    die_n       = die_cnt;
    move_tick_n = 1'b0;
    init_n      = 1'b0;
    grow_n      = 1'b0;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_any) begin
          state_n   = ST_PLAY;
          dir_n     = ev_dir;
          pend_n    = ev_dir;
          init_n    = 1'b1;
          score_clr = 1'b1;
          tick_n    = '0;
        end
      end
      ST_PLAY: begin
        if (ev_any && ev_dir != opposite(dir_q)) pend_n = ev_dir;
        tick_n = (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TICK_W'(1);
        if (hit) begin
          state_n = ST_DIE;
          die_n   = DIE_LOAD;
        end else begin
          // Turn is committed on the very edge that raises move_tick.
          if (tick_n == TICK_MAX) begin
            move_tick_n = 1'b1;
            dir_n       = pend_n;
          end
          if (apple_eaten) begin
            grow_n    = 1'b1;
            score_inc = 1'b1;
          end
        end
      end
      ST_DIE: begin
        if (die_cnt == '0) state_n = ST_IDLE;
        else               die_n   = die_cnt - DIE_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dir_q     <= DIR_RIGHT;
      pend_q    <= DIR_RIGHT;
      tick_cnt  <= '0;
      die_cnt   <= '0;
      btn_q     <= '0;
      move_tick <= 1'b0;
      init      <= 1'b0;
      grow      <= 1'b0;
    end else begin
      state     <= state_n;
      dir_q     <= dir_n;
      pend_q    <= pend_n;
      tick_cnt  <= tick_n;
      die_cnt   <= die_n;
      btn_q     <= btn;
      move_tick <= move_tick_n;
      init      <= init_n;
      grow      <= grow_n;
    end
  end

  assign game_state = state;
  assign dir        = dir_q;

  snake_score_bcd u_score (
    .clk   (clk),
    .rst   (rst),
    .clear (score_clr),
    .inc   (score_inc),
    .score (score_bcd)
  );

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl (MOVE_DIV=4, DIE_CYCLES=8): stimulus
// pushes expected output events, a negedge monitor pops and compares them.
module tb_snake_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic        hit = 1'b0, apple_eaten = 1'b0;
  logic [1:0]  game_state, dir;
  logic        move_tick, init, grow;
  logic [15:0] score_bcd;

  snake_game_ctrl #(.MOVE_DIV(4), .DIE_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .hit         (hit),
    .apple_eaten (apple_eaten),
    .game_state  (game_state),
    .dir         (dir),
    .move_tick   (move_tick),
    .init        (init),
    .grow        (grow),
    .score_bcd   (score_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {int c; logic [1:0] gs; logic [1:0] d; logic [15:0] s;} st_exp_t;
  typedef struct {int c; logic [1:0] d;} tick_exp_t;

  st_exp_t     q_state[$];
  tick_exp_t   q_tick[$];
  logic [1:0]  q_init[$];
  logic [15:0] q_grow[$];

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  logic rst_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: got an event, want none (cycle %0d)", nm, cyc);
  endtask

  // Monitor
  logic [1:0] last_gs = 2'd0, last_dir = 2'd3;
  always @(negedge clk) begin
    if (!rst) begin
      if (rst_at_edge || game_state != last_gs) begin
        if (q_state.size() == 0) unexpected("state_change");
        else begin
          st_exp_t e;
          e = q_state.pop_front();
          chk("state_cycle", cyc, e.c);
          chk("state_value", game_state, e.gs);
          chk("state_dir", dir, e.d);
          chk("state_score", score_bcd, e.s);
        end
      end else if (dir != last_dir && !move_tick && !init) begin
        unexpected("dir_change");
      end
      if (move_tick) begin
        if (q_tick.size() == 0) unexpected("move_tick");
        else begin
          tick_exp_t t;
          t = q_tick.pop_front();
          chk("tick_cycle", cyc, t.c);
          chk("tick_dir", dir, t.d);
        end
      end
      if (init) begin
        if (q_init.size() == 0) unexpected("init");
        else begin
          chk("init_dir", dir, q_init.pop_front());
          chk("init_score", score_bcd, 16'h0000);
        end
      end
      if (grow) begin
        if (q_grow.size() == 0) unexpected("grow");
        else chk("grow_score", score_bcd, q_grow.pop_front());
      end
      last_gs  = game_state;
      last_dir = dir;
    end
  end

  // Reference of the play phase, advanced one edge at a time.
  bit         m_play = 0;
  int         m_pc = 0;
  logic [1:0] m_dir = 2'd3, m_pend = 2'd3;

  task automatic tick_clk();
    @(posedge clk);
    #1;
    if (m_play) begin
      m_pc++;
      if (m_pc % 4 == 3) begin
        m_dir = m_pend;
        q_tick.push_back('{cyc, m_dir});
      end
    end
  endtask

  task automatic expect_start(input logic [1:0] d);
    q_init.push_back(d);
    q_state.push_back('{cyc + 1, 2'd1, d, 16'h0000});
    m_play = 1;
    m_pc   = -1;
    m_dir  = d;
    m_pend = d;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic apple(input int n);
    apple_eaten = 1'b1;
    q_grow.push_back(to_bcd(n > 9999 ? 9999 : n));
    tick_clk();
    apple_eaten = 1'b0;
    tick_clk();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state
    q_state.push_back('{3, 2'd0, 2'd3, 16'h0000});
    repeat (3) tick_clk();
    rst = 1'b0;
    repeat (2) tick_clk();

    // Start with right held for three cycles: a single init
    right = 1'b1;
    expect_start(2'd3);
    repeat (3) tick_clk();
    right = 1'b0;
    repeat (8) tick_clk();

    // Reverse press is discarded; up+down together -> up wins
    left = 1'b1;
    tick_clk();
    left = 1'b0;
    tick_clk();
    up = 1'b1; down = 1'b1; m_pend = 2'd0;
    tick_clk();
    up = 1'b0; down = 1'b0;
    repeat (4) tick_clk();

    // Up then left inside one tick period -> single turn to left
    while (m_pc % 4 != 3) tick_clk();
    up = 1'b1;
    tick_clk();
    up = 1'b0; left = 1'b1; m_pend = 2'd2;
    tick_clk();
    left = 1'b0;
    repeat (2) tick_clk();

    // Twelve apples
    for (int i = 1; i <= 12; i++) apple(i);
    repeat (3) tick_clk();

    // hit and apple together: DIE, no grow, score kept, back to IDLE after 8
    hit = 1'b1; apple_eaten = 1'b1; m_play = 0;
    q_state.push_back('{cyc + 1, 2'd2, m_dir, 16'h0012});
    tick_clk();
    q_state.push_back('{cyc + 8, 2'd0, m_dir, 16'h0012});
    up = 1'b1;
    tick_clk();
    up = 1'b0; apple_eaten = 1'b0;
    tick_clk();
    hit = 1'b0;
    repeat (8) tick_clk();

    // IDLE ignores hit and apple_eaten
    hit = 1'b1; apple_eaten = 1'b1;
    tick_clk();
    hit = 1'b0; apple_eaten = 1'b0;
    tick_clk();

    // Restart with up, then drive the score into saturation
    up = 1'b1;
    expect_start(2'd0);
    tick_clk();
    up = 1'b0;
    for (int i = 1; i <= 10000; i++) apple(i);
    tick_clk();

    // Down (reverse, discarded) held into a reset at counter value 2
    while (m_pc % 4 != 0) tick_clk();
    down = 1'b1;
    tick_clk();
    tick_clk();
    rst = 1'b1; m_play = 0;
    q_state.push_back('{cyc + 1, 2'd0, 2'd3, 16'h0000});
    tick_clk();
    rst = 1'b0;
    expect_start(2'd1);
    tick_clk();
    down = 1'b0;
    repeat (9) tick_clk();

    chk("leftover_state", q_state.size(), 0);
    chk("leftover_tick", q_tick.size(), 0);
    chk("leftover_init", q_init.size(), 0);
    chk("leftover_grow", q_grow.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
